line_buffer_window: RTL and testbench

- Parametrised sliding-window line buffer for the HOG front end.
- Accepts a raster pixel stream and presents a KERNEL_SIZE x KERNEL_SIZE window per accepted pixel, for CHANNELS parallel channels.
- Image width is set at run time, not at synthesis.
- Flags windows that straddle the left/right image edge or sit in the top rows, so downstream gradient/cell logic can skip them.

---
 rtl/linebuf_pkg.sv | 29 ++
 rtl/line_fifo.sv | 61 ++++++
 rtl/line_buffer_window.sv | 190 +++++++++++++++++++
 tb/tb_line_buffer_window.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/linebuf_pkg.sv
// Shared types and helpers for the sliding-window line buffer.
package linebuf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2
  } lb_state_t;

  localparam int unsigned LB_DEF_MAX_LINE_WIDTH = 1024;
  localparam int unsigned LB_DEF_ADDR_WIDTH     = $clog2(LB_DEF_MAX_LINE_WIDTH);
  localparam int unsigned LB_DEF_WIN_WIDTH      = 3 * 3 * 1 * 8;

  function automatic int unsigned lb_addr_width(input int unsigned max_w);
    return (max_w < 2) ? 1 : $clog2(max_w);
  endfunction

  function automatic int unsigned lb_win_width(input int unsigned k, input int unsigned ch,
                                               input int unsigned dw);
    return k * k * ch * dw;
  endfunction

  // Flat position of window entry [r][c]; row 0 and column 0 are the oldest.
  function automatic int unsigned win_idx(input int unsigned r, input int unsigned c,
                                          input int unsigned k);
    return r * k + c;
  endfunction

endpackage

// File: rtl/line_fifo.sv
// One line delay of runtime length i_line_width; output is the sample written
// exactly i_line_width enables ago, prefetched so it is ready before the next enable.
module line_fifo
  import linebuf_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned MAX_LINE_WIDTH = 1024,
  parameter int unsigned LW_WIDTH       = $clog2(MAX_LINE_WIDTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LW_WIDTH-1:0] i_line_width,
  input  logic                i_clr,
  input  logic                i_en,
  input  logic [WIDTH-1:0]    i_data,
  output logic [WIDTH-1:0]    o_data
);

  localparam int unsigned AW = lb_addr_width(MAX_LINE_WIDTH);

  logic [WIDTH-1:0] r_mem [MAX_LINE_WIDTH];
  logic [AW-1:0]    r_addr;
  logic [WIDTH-1:0] r_rd_data;
  logic [WIDTH-1:0] r_byp_data;
  logic             r_bypass;
  logic             w_wrap;
  logic [AW-1:0]    w_addr_next;
  logic [AW-1:0]    w_rd_addr;

  assign w_wrap      = (LW_WIDTH'(r_addr) == i_line_width - LW_WIDTH'(1));
  assign w_addr_next = w_wrap ? '0 : r_addr + AW'(1);
  // Read one slot ahead so the delayed sample is already registered when the
  // next pixel arrives; the RAM port itself is read-before-write.
  assign w_rd_addr   = i_en ? w_addr_next : (i_clr ? '0 : r_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr   <= '0;
      r_bypass <= 1'b0;
    end else begin
      if (i_en) begin
        r_addr <= w_addr_next;
      end else if (i_clr) begin
        r_addr <= '0;
      end
      // A one-pixel line re-reads the slot being written: forward the new sample.
      r_bypass <= i_en && (w_addr_next == r_addr);
    end
  end

  always_ff @(posedge clk) begin
    if (i_en) begin
      r_mem[r_addr] <= i_data;
    end
    r_rd_data  <= r_mem[w_rd_addr];
    r_byp_data <= i_data;
  end

  assign o_data = r_bypass ? r_byp_data : r_rd_data;

endmodule

// File: rtl/line_buffer_window.sv
// KxK sliding-window line buffer with runtime line width and border/eof flags.
// Define LINEBUF_ERR_EN to add the err_sticky configuration-error output.
module line_buffer_window
  import linebuf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned CHANNELS       = 1,
  parameter int unsigned MAX_LINE_WIDTH = 1024,
  parameter int unsigned KERNEL_SIZE    = 3,
  parameter int unsigned LW_WIDTH       = $clog2(MAX_LINE_WIDTH + 1)
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic [LW_WIDTH-1:0]                                    line_width,
  input  logic [15:0]                                            frame_height,
  input  logic [CHANNELS*DATA_WIDTH-1:0]                         s_data,
  input  logic                                                   s_valid,
  output logic                                                   s_ready,
  output logic [KERNEL_SIZE*KERNEL_SIZE*CHANNELS*DATA_WIDTH-1:0] m_window,
  output logic                                                   m_valid,
  input  logic                                                   m_ready,
  output logic                                                   m_border,
  output logic                                                   m_eof
`ifdef LINEBUF_ERR_EN
  ,
  output logic                                                   err_sticky
`endif
);

  localparam int unsigned K    = KERNEL_SIZE;
  localparam int unsigned PW   = CHANNELS * DATA_WIDTH;
  localparam int unsigned WINW = lb_win_width(K, CHANNELS, DATA_WIDTH);

  localparam logic [LW_WIDTH-1:0] MAX_LW  = LW_WIDTH'(MAX_LINE_WIDTH);
  localparam logic [LW_WIDTH-1:0] COL_KM1 = LW_WIDTH'(K - 1);
  localparam logic [15:0]         ROW_KM1 = 16'(K - 1);
  localparam logic [15:0]         ROW_K   = 16'(K);

  lb_state_t           r_state;
  lb_state_t           w_state_next;
  logic [LW_WIDTH-1:0] r_lw;
  logic [15:0]         r_fh;
  logic [LW_WIDTH-1:0] r_col;
  logic [15:0]         r_row;
  logic [15:0]         w_row_next;
  logic                r_m_valid;
  logic                r_m_border;
  logic                r_m_eof;
  logic [PW-1:0]       r_win [K][K];

  logic                w_idle;
  logic [LW_WIDTH-1:0] w_lw;
  logic [15:0]         w_fh;
  logic                w_misconfig;
  logic                w_sink;
  logic                w_accept;
  logic                w_eol;
  logic                w_eof;
  logic                w_border;
  logic [PW-1:0]       w_fifo_in [K-1];
  logic [PW-1:0]       w_line    [K-1];
  logic [PW-1:0]       w_col_in  [K];

  // Configuration is only taken from the inputs until the first pixel of a frame.
  assign w_idle      = (r_state == ST_IDLE);
  assign w_lw        = w_idle ? line_width : r_lw;
  assign w_fh        = w_idle ? frame_height : r_fh;
  assign w_misconfig = (line_width == '0) || (line_width > MAX_LW) || (frame_height < ROW_K);
  assign w_sink      = w_idle && w_misconfig;

  assign s_ready  = !rst && (w_sink || !r_m_valid || m_ready);
  assign w_accept = s_valid && s_ready && !w_sink;

  assign w_eol    = (r_col == w_lw - LW_WIDTH'(1));
  assign w_eof    = w_eol && (r_row == w_fh - 16'd1);
  assign w_border = (r_row < ROW_KM1) || (r_col < COL_KM1);

  genvar gi, gj;
  generate
    for (gi = 0; gi < K - 1; gi++) begin : g_line
      if (gi == 0) begin : g_head
        assign w_fifo_in[gi] = s_data;
      end else begin : g_chain
        assign w_fifo_in[gi] = w_line[gi-1];
      end

      line_fifo #(
        .WIDTH         (PW),
        .MAX_LINE_WIDTH(MAX_LINE_WIDTH),
        .LW_WIDTH      (LW_WIDTH)
      ) u_line_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_line_width(w_lw),
        .i_clr       (w_idle),
        .i_en        (w_accept),
        .i_data      (w_fifo_in[gi]),
        .o_data      (w_line[gi])
      );
    end

    // Newest row takes the live pixel; older rows take progressively longer delays.
    for (gi = 0; gi < K; gi++) begin : g_col
      if (gi == K - 1) begin : g_live
        assign w_col_in[gi] = s_data;
      end else begin : g_delayed
        assign w_col_in[gi] = w_line[K-2-gi];
      end
    end

    for (gi = 0; gi < K; gi++) begin : g_win_r
      for (gj = 0; gj < K; gj++) begin : g_win_c
        assign m_window[win_idx(gi, gj, K)*PW +: PW] = r_win[gi][gj];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          if (c == K - 1) begin
            r_win[r][c] <= w_col_in[r];
          end else begin
            r_win[r][c] <= r_win[r][c+1];
          end
        end
      end
    end
  end

  always_comb begin
    w_row_next   = w_eol ? r_row + 16'd1 : r_row;
    w_state_next = ST_FILL;
    if (w_eof) begin
      w_state_next = ST_IDLE;
    end else if (w_row_next >= ROW_KM1) begin
      w_state_next = ST_STREAM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_lw       <= '0;
      r_fh       <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_m_valid  <= 1'b0;
      r_m_border <= 1'b0;
      r_m_eof    <= 1'b0;
    end else if (w_accept) begin
      r_m_valid  <= 1'b1;
      r_m_border <= w_border;
      r_m_eof    <= w_eof;
      r_state    <= w_state_next;
      if (w_idle) begin
        r_lw <= line_width;
        r_fh <= frame_height;
      end
      if (w_eol) begin
        r_col <= '0;
        r_row <= w_eof ? 16'd0 : w_row_next;
      end else begin
        r_col <= r_col + LW_WIDTH'(1);
      end
    end else if (m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  assign m_valid  = r_m_valid;
  assign m_border = r_m_border;
  assign m_eof    = r_m_eof;

`ifdef LINEBUF_ERR_EN
  logic r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_sink || (!w_idle && ((line_width != r_lw) || (frame_height != r_fh)))) begin
      r_err <= 1'b1;
    end
  end

  assign err_sticky = r_err;
`endif

endmodule

// File: tb/tb_line_buffer_window.sv
// Directed bench for line_buffer_window (K=3, 8-bit, 1 channel, 1024 max width).
module tb_line_buffer_window;

  localparam int K    = 3;
  localparam int DW   = 8;
  localparam int MAXW = 1024;
  localparam int LWW  = $clog2(MAXW + 1);
  localparam int WINW = K * K * DW;

  typedef struct {
    int width;
    int height;
    int salt;
    int vpct;
    int rpct;
    int exp_windows;
    int exp_first_clean;
  } frame_vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [LWW-1:0]   line_width;
  logic [15:0]      frame_height;
  logic [DW-1:0]    s_data;
  logic             s_valid;
  logic             s_ready;
  logic [WINW-1:0]  m_window;
  logic             m_valid;
  logic             m_ready;
  logic             m_border;
  logic             m_eof;
`ifdef LINEBUF_ERR_EN
  logic             err_sticky;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  logic [WINW-1:0] got_win[$];

  always #5 clk = ~clk;

  line_buffer_window #(
    .DATA_WIDTH    (DW),
    .CHANNELS      (1),
    .MAX_LINE_WIDTH(MAXW),
    .KERNEL_SIZE   (K),
    .LW_WIDTH      (LWW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .line_width  (line_width),
    .frame_height(frame_height),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .m_window    (m_window),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_border    (m_border),
    .m_eof       (m_eof)
`ifdef LINEBUF_ERR_EN
    ,
    .err_sticky  (err_sticky)
`endif
  );

  task automatic check(input string name, input logic [WINW-1:0] got, input logic [WINW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pix(input int r, input int c, input int salt);
    return DW'((r * 16 + c) ^ salt);
  endfunction

  // Expected window straight from image coordinates: entry [wr][wc] is pixel
  // (r-2+wr, c-2+wc), row 0 / column 0 oldest, index wr*K+wc.
  function automatic logic [WINW-1:0] exp_win(input int r, input int c, input int salt);
    logic [WINW-1:0] e;
    e = '0;
    for (int wr = 0; wr < K; wr++) begin
      for (int wc = 0; wc < K; wc++) begin
        e[(wr*K+wc)*DW +: DW] = pix(r - (K - 1) + wr, c - (K - 1) + wc, salt);
      end
    end
    return e;
  endfunction

  task automatic run_frame(input int fid, input frame_vec_t v);
    int total, in_idx, out_idx, cycles, stalls, first_clean, budget, r, c;
    logic prev_stall;
    logic [WINW-1:0] prev_win;
    logic prev_border, prev_eof;
    total = v.width * v.height;
    budget = 20 * total + 200;
    in_idx = 0; out_idx = 0; cycles = 0; stalls = 0; first_clean = -1;
    prev_stall = 1'b0; prev_win = '0; prev_border = 1'b0; prev_eof = 1'b0;
    got_win.delete();
    @(negedge clk);
    line_width = LWW'(v.width);
    frame_height = 16'(v.height);
    while (out_idx < total && cycles < budget) begin
      if (prev_stall) begin
        check($sformatf("f%0d_hold[%0d]", fid, out_idx),
              WINW'({m_valid, m_border, m_eof, m_window}),
              WINW'({1'b1, prev_border, prev_eof, prev_win}));
      end
      m_ready = ($urandom_range(0, 99) < v.rpct);
      s_valid = (in_idx < total) && ($urandom_range(0, 99) < v.vpct);
      s_data  = pix(in_idx / v.width, in_idx % v.width, v.salt);
      #1;
      if (s_valid && !s_ready) stalls++;
      if (m_valid && m_ready) begin
        r = out_idx / v.width;
        c = out_idx % v.width;
        check($sformatf("f%0d_border[%0d]", fid, out_idx), WINW'(m_border),
              WINW'((r < K - 1) || (c < K - 1)));
        check($sformatf("f%0d_eof[%0d]", fid, out_idx), WINW'(m_eof),
              WINW'(out_idx == total - 1));
        if (r >= K - 1 && c >= K - 1) begin
          check($sformatf("f%0d_win[%0d,%0d]", fid, r, c), m_window, exp_win(r, c, v.salt));
        end
        if (!m_border && first_clean < 0) first_clean = out_idx;
        got_win.push_back(m_window);
        out_idx++;
      end
      prev_stall  = m_valid && !m_ready;
      prev_win    = m_window;
      prev_border = m_border;
      prev_eof    = m_eof;
      if (s_valid && s_ready) in_idx++;
      cycles++;
      @(negedge clk);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    check($sformatf("f%0d_count", fid), WINW'(out_idx), WINW'(v.exp_windows));
    check($sformatf("f%0d_first_clean", fid), WINW'(first_clean), WINW'(v.exp_first_clean));
    if (v.rpct == 100) begin
      check($sformatf("f%0d_stalls", fid), WINW'(stalls), WINW'(0));
    end
    if (v.rpct == 100 && v.vpct == 100) begin
      check($sformatf("f%0d_cycles", fid), WINW'(cycles), WINW'(total + 1));
    end
    repeat (3) @(negedge clk);
    check($sformatf("f%0d_no_extra", fid), WINW'(m_valid), WINW'(0));
    $display("frame %0d: %0dx%0d windows=%0d cycles=%0d", fid, v.width, v.height, out_idx, cycles);
  endtask

  initial begin
    frame_vec_t vecs[6];
    int bad_lw[3];
    int bad_fh[3];
    int cnt, cyc;

    vecs[0] = '{8,    4, 8'h5A, 100, 100,   32,   18};
    vecs[1] = '{5,    4, 0,     100, 100,   20,   12};
    vecs[2] = '{16,   6, 8'h33,  70,  30,   96,   34};
    vecs[3] = '{6,    4, 8'h11, 100, 100,   24,   14};
    vecs[4] = '{10,   5, 8'h22,  90,  80,   50,   22};
    vecs[5] = '{1024, 3, 8'h07, 100, 100, 3072, 2050};
    bad_lw = '{0, 1025, 8};
    bad_fh = '{4, 4, 2};

    rst = 1'b1;
    line_width = LWW'(8);
    frame_height = 16'd4;
    s_data = '0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset_state", WINW'({s_ready, m_valid, m_border, m_eof}), WINW'(0));
`ifdef LINEBUF_ERR_EN
    check("reset_err", WINW'(err_sticky), WINW'(0));
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("post_reset_ready", WINW'({s_ready, m_valid}), WINW'(2'b10));

    // Abort a frame after 12 pixels.
    cnt = 0;
    cyc = 0;
    while (cnt < 12 && cyc < 100) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data = DW'(cnt + 8'hC0);
      #1;
      if (s_ready) cnt++;
      cyc++;
    end
    check("midframe_fed", WINW'(cnt), WINW'(12));
    @(negedge clk);
    check("midframe_valid_before", WINW'(m_valid), WINW'(1));
    s_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midframe_rst", WINW'({m_valid, s_ready, m_eof}), WINW'(0));
    rst = 1'b0;
    @(negedge clk);
    check("midframe_after", WINW'(m_valid), WINW'(0));
    $display("midframe reset: fed=%0d", cnt);

    for (int i = 0; i < 6; i++) begin
      run_frame(i, vecs[i]);
      if (i == 1) begin
        check("ramp_size", WINW'(got_win.size()), WINW'(20));
        if (got_win.size() == 20) begin
          check("ramp_win_3_4", got_win[19], 72'h34_33_32_24_23_22_14_13_12);
        end
      end
    end

    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      line_width = LWW'(bad_lw[b]);
      frame_height = 16'(bad_fh[b]);
      for (int t = 0; t < 6; t++) begin
        @(negedge clk);
        s_valid = 1'b1;
        m_ready = 1'b1;
        s_data = DW'(t);
        #1;
        check($sformatf("mis%0d_ready[%0d]", b, t), WINW'({s_ready, m_valid}), WINW'(2'b10));
      end
      @(negedge clk);
      s_valid = 1'b0;
      #1;
      check($sformatf("mis%0d_no_valid", b), WINW'(m_valid), WINW'(0));
`ifdef LINEBUF_ERR_EN
      check($sformatf("mis%0d_err_set", b), WINW'(err_sticky), WINW'(1));
`endif
      line_width = LWW'(5);
      frame_height = 16'd4;
`ifdef LINEBUF_ERR_EN
      @(negedge clk);
      check($sformatf("mis%0d_err_stays", b), WINW'(err_sticky), WINW'(1));
`endif
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
`ifdef LINEBUF_ERR_EN
      check($sformatf("mis%0d_err_clr", b), WINW'(err_sticky), WINW'(0));
`endif
      $display("misconfig %0d: lw=%0d fh=%0d", b, bad_lw[b], bad_fh[b]);
    end

    run_frame(6, vecs[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
